seq_wide_adder: RTL and testbench

//  Multi-cycle wide adder that feeds one 16-bit ripple-carry adder (rca_16bit) a chunk per clock.

---
 rtl/adder_pkg.sv | 12 +
 rtl/rca_16bit.sv | 25 ++
 rtl/seq_wide_adder.sv | 120 ++++++++++++
 tb/tb_seq_wide_adder.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared constants and FSM state type for the sequential wide adder
package adder_pkg;

  localparam int CHUNK_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/rca_16bit.sv
// rtl/rca_16bit.sv - purely combinational 16-bit ripple-carry chunk adder
module rca_16bit
  import adder_pkg::*;
(
  input  logic [CHUNK_W-1:0] a,
  input  logic [CHUNK_W-1:0] b,
  input  logic               cin,
  output logic [CHUNK_W-1:0] sum,
  output logic               cout
);

  logic [CHUNK_W:0] carry;

  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = cin;
    for (int i = 0; i < CHUNK_W; i++) begin
      sum[i]     = a[i] ^ b[i] ^ carry[i];
      carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
    cout = carry[CHUNK_W];
  end

endmodule

// File: rtl/seq_wide_adder.sv
// rtl/seq_wide_adder.sv - multi-cycle wide adder, one 16-bit chunk per clock, LSB chunk first
module seq_wide_adder
  import adder_pkg::*;
#(
  parameter  int N_CHUNKS = 4,
  localparam int W        = CHUNK_W * N_CHUNKS
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         ovf
);

  localparam int IDX_W = $clog2(N_CHUNKS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_CHUNKS - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [W-1:0]     sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             ready_arm_q;

  logic [CHUNK_W-1:0] a_chunk, b_chunk, rca_sum;
  logic               rca_cout;

  assign a_chunk = a_q[idx_q*CHUNK_W +: CHUNK_W];
  assign b_chunk = b_q[idx_q*CHUNK_W +: CHUNK_W];

  rca_16bit u_rca (
    .a    (a_chunk),
    .b    (b_chunk),
    .cin  (carry_q),
    .sum  (rca_sum),
    .cout (rca_cout)
  );

  // ready_arm_q keeps in_ready low until the first edge after reset release
  assign in_ready  = ready_arm_q && (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[idx_q*CHUNK_W +: CHUNK_W] = rca_sum;
        carry_d = rca_cout;
        if (idx_q == IDX_LAST) begin
          cout_d  = rca_cout;
          ovf_d   = (a_q[W-1] == b_q[W-1]) && (rca_sum[CHUNK_W-1] != a_q[W-1]);
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          idx_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      ready_arm_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      ready_arm_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_seq_wide_adder.sv
// tb/tb_seq_wide_adder.sv - directed and randomized self-checking bench for seq_wide_adder
module tb_seq_wide_adder;

  localparam int N = 4;
  localparam int W = 16 * N;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int tests = 0;
  int fails = 0;
  int pops  = 0;

  seq_wide_adder #(.N_CHUNKS(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_result(input string tag, input logic [W-1:0] ea, input logic [W-1:0] eb,
                               input logic ec);
    logic [W:0] full;
    logic       eovf;
    full = {1'b0, ea} + {1'b0, eb} + {{W{1'b0}}, ec};
    eovf = (ea[W-1] == eb[W-1]) && (full[W-1] != ea[W-1]);
    check({tag, "_sum"}, sum, full[W-1:0]);
    check({tag, "_cout"}, W'(cout), W'(full[W]));
    check({tag, "_ovf"}, W'(ovf), W'(eovf));
  endtask

  // Drives one operand set, checks the exact N-edge latency, leaves the result in DONE.
  task automatic start_op(input string tag, input logic [W-1:0] oa, input logic [W-1:0] ob,
                          input logic oc);
    int n;
    a = oa; b = ob; cin = oc; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_in_ready"}, W'(in_ready), W'(1));
    tick();
    in_valid = 1'b0;
    a = ~oa; b = ~ob; cin = ~oc;
    for (int i = 0; i < N - 1; i++) tick();
    check({tag, "_early_valid"}, W'(out_valid), W'(0));
    tick();
    check({tag, "_out_valid"}, W'(out_valid), W'(1));
  endtask

  task automatic pop(input string tag);
    check({tag, "_ready_in_done"}, W'(in_ready), W'(0));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, W'(out_valid), W'(0));
    check({tag, "_ready_after_pop"}, W'(in_ready), W'(1));
  endtask

  initial begin
    logic [W-1:0] ra, rb, held;
    logic         rc;
    int           n;
    logic         popped;

    // Reset held for three cycles, then released between edges
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_in_ready", W'(in_ready), W'(0));
      check("rst_out_valid", W'(out_valid), W'(0));
      check("rst_sum", sum, '0);
    end
    rst_n = 1'b1;
    #1;
    check("rel_in_ready_before_edge", W'(in_ready), W'(0));
    tick();
    check("rel_in_ready", W'(in_ready), W'(1));
    check("rel_out_valid", W'(out_valid), W'(0));

    // Basic carry across a chunk boundary
    start_op("basic", 64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0);
    check("basic_sum_const", sum, 64'h0000_0001_0000_0000);
    expect_result("basic", 64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0);

    // Asynchronous reset mid-cycle while a result is pending
    #2;
    rst_n = 1'b0;
    #1;
    check("async_out_valid", W'(out_valid), W'(0));
    check("async_sum", sum, '0);
    check("async_cout", W'(cout), W'(0));
    check("async_in_ready", W'(in_ready), W'(0));
    tick();
    rst_n = 1'b1;
    tick();

    // Full wrap and signed overflow
    start_op("wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1);
    check("wrap_sum_const", sum, 64'h0);
    check("wrap_cout_const", W'(cout), W'(1));
    expect_result("wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1);
    pop("wrap");
    start_op("sovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0);
    check("sovf_sum_const", sum, 64'hFFFF_FFFF_FFFF_FFFE);
    check("sovf_ovf_const", W'(ovf), W'(1));
    expect_result("sovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0);
    pop("sovf");

    // Backpressure with ignored input pulses
    start_op("bp", 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1);
    held = sum;
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      a = 64'hDEAD_BEEF_0000_0000 + 64'(i);
      b = 64'h5;
      tick();
      check("bp_sum_stable", sum, held);
      check("bp_in_ready", W'(in_ready), W'(0));
      check("bp_out_valid", W'(out_valid), W'(1));
    end
    in_valid = 1'b0;
    expect_result("bp", 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1);
    pop("bp");
    for (int i = 0; i < N + 2; i++) begin
      tick();
      check("bp_no_queued_op", W'(out_valid), W'(0));
    end

    // Reset two cycles into RUN aborts the op
    a = 64'hAAAA_AAAA_AAAA_AAAA; b = 64'h5555_5555_5555_5555; cin = 1'b1; in_valid = 1'b1;
    check("abort_in_ready", W'(in_ready), W'(1));
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", W'(out_valid), W'(0));
    check("abort_sum", sum, '0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < N + 2; i++) begin
      tick();
      check("abort_no_result", W'(out_valid), W'(0));
    end
    start_op("after_abort", 64'h0001_0002_0003_FFFF, 64'h0004_0005_0006_0001, 1'b0);
    check("after_abort_const", sum, 64'h0005_0007_000A_0000);
    expect_result("after_abort", 64'h0001_0002_0003_FFFF, 64'h0004_0005_0006_0001, 1'b0);
    pop("after_abort");

    // Randomized traffic with random gaps and consumer stalls
    for (int k = 0; k < 1000; k++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rc = 1'($urandom_range(0, 1));
      if (k % 7 == 0) rb = ~ra;
      n = $urandom_range(0, 2);
      for (int g = 0; g < n; g++) tick();
      a = ra; b = rb; cin = rc; in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 20) begin
        tick();
        n++;
      end
      check("rnd_in_ready", W'(in_ready), W'(1));
      tick();
      in_valid = 1'b0;
      a = {$urandom, $urandom}; b = {$urandom, $urandom}; cin = 1'($urandom_range(0, 1));
      popped = 1'b0;
      n = 0;
      while (!popped && n < 100) begin
        out_ready = 1'($urandom_range(0, 1));
        #1;
        if (out_valid && out_ready) begin
          expect_result("rnd", ra, rb, rc);
          pops++;
          popped = 1'b1;
        end
        tick();
        n++;
      end
      out_ready = 1'b0;
      check("rnd_popped", W'(popped), W'(1));
      check("rnd_no_dup", W'(out_valid), W'(0));
    end
    check("rnd_pop_count", W'(pops), W'(1000));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
